code_match_game: RTL
====================

Name: code_match_game

Overview:
- Memory-game controller directly downstream of the 4-bit pseudo-random code generator.
- Captures one new random code per round and appends it to a sequence buffer.
- Replays the whole sequence to the display, one code per tick, then checks the player's entries against the buffer.
- Tracks level and score, and ends each game in a held win or lose condition.

Parameters:
SEQ_LEN, 8, maximum sequence length; reaching it with a correct round is a win (2..15)
TIMEOUT_TICKS, 5, ticks allowed between player entries before a lose (1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high; clears all state immediately
tick  input  1  one-clk-wide pacing strobe (~1 Hz enable); no second clock is used
start  input  1  one-clk pulse; begins a new game from IDLE, WIN or LOSE
code  input  4  random code from the generator; sampled only in LOAD
key_valid  input  1  one-clk strobe; player entry present on key
key  input  4  player-entered code
show_valid  output  1  high while a sequence element is being displayed
show_code  output  4  displayed element; 4'h0 when show_valid is low
await_input  output  1  high in INPUT state
win  output  1  high in WIN state (held)
lose  output  1  high in LOSE state (held)
level  output  4  current sequence length; 0 in IDLE
score  output  4  completed correct rounds in the current game

Behaviour:
- Reset values (asynchronous, immediate):
  - state IDLE; buffer index 0; timeout counter 0.
  - level, score 0; every output 0.
  - Buffer contents need not be cleared.
- Priority: reset > everything else.
- States: IDLE, LOAD, SHOW, INPUT, WIN, LOSE.
- IDLE:
  - start -> level=1, score=0, go to LOAD.
  - tick and key_valid are ignored.
- LOAD (exactly 1 clk):
  - buf[level-1] <= code; idx <= 0; go to SHOW.
- SHOW:
  - show_valid=1, show_code=buf[idx]; the first element is visible the cycle after LOAD.
  - Each tick advances idx.
  - A tick at idx==level-1 -> idx <= 0, timeout counter <= 0, go to INPUT.
  - key_valid and start are ignored.
- INPUT:
  - await_input=1.
  - key_valid with key!=buf[idx] -> LOSE.
  - key_valid with key==buf[idx] and idx<level-1 -> idx++, timeout counter cleared.
  - key_valid with key==buf[idx] and idx==level-1 -> score++.
    - If level==SEQ_LEN: go to WIN.
    - Else: level++, go to LOAD.
  - tick with no key_valid -> timeout counter++; reaching TIMEOUT_TICKS -> LOSE.
  - key_valid and tick in the same cycle: key_valid is processed and the counter clears; the tick is discarded.
  - start is ignored.
- WIN / LOSE:
  - win or lose held; level and score frozen; tick and key_valid ignored.
  - start -> level=1, score=0, go to LOAD.
- Widths:
  - level and score never exceed SEQ_LEN, so no wrap occurs.
  - idx and the timeout counter are 4 bits.
- All outputs are registered or decoded from registered state; no combinational path from key to win/lose.

Test Plan:
1. Assert reset mid-SHOW with level=3 -> same-cycle outputs all 0, level=0, score=0; after release, FSM in IDLE and ignores tick/key_valid.
2. Run one correct round:
   - Stimulus: start with code=4'hA.
   - show_valid=1 and show_code=A for one tick, then await_input=1.
   - key=A with key_valid -> score=1, level=2.
   - Next LOAD captures code=4'h3; SHOW displays A then 3 on successive ticks.
3. Enter a wrong key: at level 2 with sequence {A,3}, enter A then 5 -> lose=1 held, score=1, level=2; start -> level=1, score=0, LOAD.
4. Full game with SEQ_LEN=4, codes {1,2,3,4}: answer every round correctly -> win=1 after 4th round, score=4, level=4; further key_valid and tick change nothing.
5. Timeout with TIMEOUT_TICKS=3:
   - 3 ticks with no entry in INPUT -> lose=1.
   - Repeat, entering a correct key on the same cycle as the 3rd tick -> no lose; idx advances; counter clears.
6. Start and key_valid asserted during SHOW -> ignored; display sequence, level and score unchanged.

Source files
------------

// File: rtl/code_match_game.sv
// code_match_game: memory-game controller. Each round appends one random code
// to a sequence buffer, replays the sequence one element per tick, then checks
// the player's entries. A game ends in a held WIN or LOSE.
module code_match_game #(
  parameter int unsigned SEQ_LEN       = 8,
  parameter int unsigned TIMEOUT_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] code,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic       show_valid,
  output logic [3:0] show_code,
  output logic       await_input,
  output logic       win,
  output logic       lose,
  output logic [3:0] level,
  output logic [3:0] score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] tmo_q, tmo_d;
  logic [3:0] level_q, level_d;
  logic [3:0] score_q, score_d;
  logic [3:0] seq_q [SEQ_LEN];
  logic [3:0] seq_d [SEQ_LEN];

  logic [3:0] cur_code;
  logic [3:0] last_idx;

  // Read the buffer element selected by idx
  always_comb begin
    cur_code = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (idx_q == 4'(i)) cur_code = seq_q[i];
    end
  end

  assign last_idx = level_q - 4'd1;

  // Next-state, counters and buffer write
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    level_d = level_q;
    score_d = score_q;
    seq_d   = seq_q;

    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          level_d = 4'd1;
          score_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
          if (level_q == 4'(i + 1)) seq_d[i] = code;
        end
        idx_d   = '0;
        state_d = S_SHOW;
      end

      S_SHOW: begin
        if (tick) begin
          if (idx_q == last_idx) begin
            idx_d   = '0;
            tmo_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      S_INPUT: begin
        // A key entry takes precedence; a coincident tick is discarded.
        if (key_valid) begin
          tmo_d = '0;
          if (key != cur_code) begin
            state_d = S_LOSE;
          end else if (idx_q != last_idx) begin
            idx_d = idx_q + 4'd1;
          end else begin
            score_d = score_q + 4'd1;
            if (level_q == 4'(SEQ_LEN)) begin
              state_d = S_WIN;
            end else begin
              level_d = level_q + 4'd1;
              state_d = S_LOAD;
            end
          end
        end else if (tick) begin
          tmo_d = tmo_q + 4'd1;
          if (tmo_q + 4'd1 == 4'(TIMEOUT_TICKS)) state_d = S_LOSE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tmo_q   <= '0;
      level_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      level_q <= level_d;
      score_q <= score_d;
    end
  end

  // Sequence buffer storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    seq_q <= seq_d;
  end

  // Outputs decoded from registered state
  always_comb begin
    show_valid  = (state_q == S_SHOW);
    show_code   = show_valid ? cur_code : '0;
    await_input = (state_q == S_INPUT);
    win         = (state_q == S_WIN);
    lose        = (state_q == S_LOSE);
    level       = level_q;
    score       = score_q;
  end

endmodule
